// File: rtl/npc_mem_pkg.sv
// Shared definitions for the instruction-fetch memory path: FSM states,
// the fault word, and the byte-address to word-index check.
package npc_mem_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;
  localparam logic [31:0] FETCH_FAULT_INST  = 32'h0000_0000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} fetch_state_e;

  typedef struct packed {
    logic        fault;
    logic [29:0] index;
  } addr_chk_t;

  // Offset wraps, so addresses below base land far out of range and fault.
  function automatic addr_chk_t addr_check(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] span_bytes);
    addr_chk_t   res;
    logic [31:0] offset;
    offset    = addr - base;
    res.fault = (addr[1:0] != 2'b00) || (offset >= span_bytes);
    res.index = offset[31:2];
    return res;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word RAM with one write and one registered read port; a read and a write to
// the same word at the same edge return the old contents.
module imem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [31:0]           i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-fetch responder: one outstanding word fetch, fixed latency,
// fault on misaligned or out-of-range addresses, plus a preload write port.
module imem_responder
  import npc_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        global_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_inst,
  output logic        rsp_err,
  input  logic        load_we,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data
);

  localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);

  fetch_state_e          r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;
  logic [31:0]           r_addr;
  logic                  r_rsp_err;
  logic                  r_rsp_ok;
  logic                  w_req_fire;
  logic                  w_capture;
  logic [31:0]           w_cap_addr;
  addr_chk_t             w_cap_chk;
  addr_chk_t             w_load_chk;
  logic [31:0]           w_rdata;
  logic                  w_unused_idx;

  assign req_ready  = (r_state == IDLE) && !global_rst;
  assign w_req_fire = req_valid && req_ready;

  // With LATENCY==1 the capture happens at the accepting edge, before r_addr is valid.
  assign w_cap_addr = (r_state == IDLE) ? req_addr : r_addr;
  assign w_cap_chk  = addr_check(w_cap_addr, BASE_ADDR, SPAN_BYTES);
  assign w_load_chk = addr_check(load_addr, BASE_ADDR, SPAN_BYTES);

  assign w_unused_idx = ^{w_cap_chk.index[29:ADDR_WIDTH], w_load_chk.index[29:ADDR_WIDTH]};

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_fire) begin
          if (LATENCY == 1) begin
            w_capture    = 1'b1;
            w_state_next = RESP;
          end else begin
            w_cnt_next   = CNT_W'(LATENCY - 1);
            w_state_next = WAIT;
          end
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 1'b1;
        // Capture as the counter reaches zero so rsp_valid rises at T+LATENCY.
        if (r_cnt == CNT_W'(1)) begin
          w_capture    = 1'b1;
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (global_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_rsp_err <= 1'b0;
      r_rsp_ok  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_req_fire) r_addr <= req_addr;
      if (w_capture) begin
        r_rsp_err <= w_cap_chk.fault;
        r_rsp_ok  <= !w_cap_chk.fault;
      end
    end
  end

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk    (clk),
    .i_we   (load_we && !w_load_chk.fault),
    .i_waddr(w_load_chk.index[ADDR_WIDTH-1:0]),
    .i_wdata(load_data),
    .i_re   (w_capture),
    .i_raddr(w_cap_chk.index[ADDR_WIDTH-1:0]),
    .o_rdata(w_rdata)
  );

  assign rsp_valid = (r_state == RESP);
  assign rsp_inst  = r_rsp_ok ? w_rdata : FETCH_FAULT_INST;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: a LATENCY=2 instance for most scenarios
// and a LATENCY=1 instance for back-to-back fetches.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        global_rst;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, load_we;
  logic [31:0] req_addr, rsp_inst, load_addr, load_data;

  logic        l1_req_valid, l1_req_ready, l1_rsp_valid, l1_rsp_ready, l1_rsp_err, l1_load_we;
  logic [31:0] l1_req_addr, l1_rsp_inst, l1_load_addr, l1_load_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_responder #(.LATENCY(2)) u_dut (
    .clk       (clk),
    .global_rst(global_rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_inst  (rsp_inst),
    .rsp_err   (rsp_err),
    .load_we   (load_we),
    .load_addr (load_addr),
    .load_data (load_data)
  );

  imem_responder #(.LATENCY(1)) u_dut1 (
    .clk       (clk),
    .global_rst(global_rst),
    .req_valid (l1_req_valid),
    .req_ready (l1_req_ready),
    .req_addr  (l1_req_addr),
    .rsp_valid (l1_rsp_valid),
    .rsp_ready (l1_rsp_ready),
    .rsp_inst  (l1_rsp_inst),
    .rsp_err   (l1_rsp_err),
    .load_we   (l1_load_we),
    .load_addr (l1_load_addr),
    .load_data (l1_load_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] data);
    load_we   = 1'b1;
    load_addr = addr;
    load_data = data;
    tick();
    load_we = 1'b0;
  endtask

  task automatic test_reset();
    global_rst = 1'b1;
    tick();
    tick();
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready got %b exp 0", req_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_tests++; if (rsp_inst !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_inst got %h exp 0", rsp_inst); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b exp 0", rsp_err); end
    n_tests++; if (l1_req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_l1_req_ready got %b exp 0", l1_req_ready); end
    global_rst = 1'b0;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_req_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_basic_fetch();
    load(32'h8000_0000, 32'h0000_0513);
    load(32'h8000_000C, 32'h0010_0093);
    load(32'h8000_0014, 32'hA5A5_0005);
    load(32'h8000_1000, 32'hFFFF_FFFF); // out of range, must not alias word 0
    load(32'h8000_0001, 32'hEEEE_EEEE); // misaligned, must be dropped
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    #1;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_T got %b exp 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_T1 got %b exp 0", rsp_valid); end
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_T1 got %b exp 0", req_ready); end
    tick();
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_T2 got %b exp 1", rsp_valid); end
    n_tests++; if (rsp_inst !== 32'h0000_0513) begin n_fail++; $display("FAIL basic_inst got %h exp 00000513", rsp_inst); end
    n_tests++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL basic_err got %b exp 0", rsp_err); end
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_T2 got %b exp 0", req_ready); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_done got %b exp 0", rsp_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_done got %b exp 1", req_ready); end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [3];
    addrs[0] = 32'h8000_0002;
    addrs[1] = 32'h8000_1000;
    addrs[2] = 32'h7FFF_FFFC;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1;
      req_addr  = addrs[i];
      tick();
      req_valid = 1'b0;
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fault_valid_T1[%0d] got %b exp 0", i, rsp_valid); end
      tick();
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL fault_valid_T2[%0d] got %b exp 1", i, rsp_valid); end
      n_tests++; if (rsp_err !== 1'b1) begin n_fail++; $display("FAIL fault_err[%0d] got %b exp 1", i, rsp_err); end
      n_tests++; if (rsp_inst !== 32'h0) begin n_fail++; $display("FAIL fault_inst[%0d] got %h exp 0", i, rsp_inst); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic test_stall();
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    tick();
    req_addr  = 32'h8000_0014; // second request held throughout the stall
    tick();
    for (int i = 0; i < 5; i++) begin
      n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d] got %b exp 1", i, rsp_valid); end
      n_tests++; if (rsp_inst !== 32'h0000_0513) begin n_fail++; $display("FAIL stall_inst[%0d] got %h exp 00000513", i, rsp_inst); end
      n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b exp 0", i, req_ready); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release_valid got %b exp 0", rsp_valid); end
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready got %b exp 1", req_ready); end
    tick();
    req_valid = 1'b0;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_second_accept got %b exp 0", req_ready); end
    tick();
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_second_valid got %b exp 1", rsp_valid); end
    n_tests++; if (rsp_inst !== 32'hA5A5_0005) begin n_fail++; $display("FAIL stall_second_inst got %h exp a5a50005", rsp_inst); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_read_before_write();
    req_valid = 1'b1;
    req_addr  = 32'h8000_000C;
    tick();
    req_valid = 1'b0;
    load_we   = 1'b1;
    load_addr = 32'h8000_000C;
    load_data = 32'hDEAD_BEEF;
    tick();
    load_we = 1'b0;
    n_tests++; if (rsp_inst !== 32'h0010_0093) begin n_fail++; $display("FAIL rbw_old got %h exp 00100093", rsp_inst); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    n_tests++; if (rsp_inst !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rbw_new got %h exp deadbeef", rsp_inst); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    req_valid = 1'b1;
    req_addr  = 32'h8000_000C;
    tick();
    req_valid  = 1'b0;
    global_rst = 1'b1;
    tick();
    global_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid[%0d] got %b exp 0", i, rsp_valid); end
      tick();
    end
    req_valid = 1'b1;
    req_addr  = 32'h8000_0000;
    tick();
    req_valid = 1'b0;
    tick();
    n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL abort_refetch_valid got %b exp 1", rsp_valid); end
    n_tests++; if (rsp_inst !== 32'h0000_0513) begin n_fail++; $display("FAIL abort_refetch_inst got %h exp 00000513", rsp_inst); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_back_to_back_lat1();
    l1_load_we   = 1'b1;
    l1_load_addr = 32'h8000_0000;
    l1_load_data = 32'h1111_1111;
    tick();
    l1_load_addr = 32'h8000_0004;
    l1_load_data = 32'h2222_2222;
    tick();
    l1_load_we   = 1'b0;
    l1_req_valid = 1'b1;
    l1_req_addr  = 32'h8000_0000;
    #1;
    n_tests++; if (l1_req_ready !== 1'b1) begin n_fail++; $display("FAIL l1_ready_T got %b exp 1", l1_req_ready); end
    tick();
    n_tests++; if (l1_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL l1_valid_T1 got %b exp 1", l1_rsp_valid); end
    n_tests++; if (l1_rsp_inst !== 32'h1111_1111) begin n_fail++; $display("FAIL l1_inst0 got %h exp 11111111", l1_rsp_inst); end
    n_tests++; if (l1_req_ready !== 1'b0) begin n_fail++; $display("FAIL l1_ready_T1 got %b exp 0", l1_req_ready); end
    l1_req_addr = 32'h8000_0004;
    tick();
    n_tests++; if (l1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL l1_valid_T2 got %b exp 0", l1_rsp_valid); end
    n_tests++; if (l1_req_ready !== 1'b1) begin n_fail++; $display("FAIL l1_ready_T2 got %b exp 1", l1_req_ready); end
    tick();
    l1_req_valid = 1'b0;
    n_tests++; if (l1_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL l1_valid_T3 got %b exp 1", l1_rsp_valid); end
    n_tests++; if (l1_rsp_inst !== 32'h2222_2222) begin n_fail++; $display("FAIL l1_inst1 got %h exp 22222222", l1_rsp_inst); end
    n_tests++; if (l1_rsp_err !== 1'b0) begin n_fail++; $display("FAIL l1_err got %b exp 0", l1_rsp_err); end
    tick();
    n_tests++; if (l1_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL l1_valid_T4 got %b exp 0", l1_rsp_valid); end
  endtask

  initial begin
    global_rst   = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    rsp_ready    = 1'b0;
    load_we      = 1'b0;
    load_addr    = 32'h0;
    load_data    = 32'h0;
    l1_req_valid = 1'b0;
    l1_req_addr  = 32'h0;
    l1_rsp_ready = 1'b1;
    l1_load_we   = 1'b0;
    l1_load_addr = 32'h0;
    l1_load_data = 32'h0;

    test_reset();
    test_basic_fetch();
    test_fault();
    test_stall();
    test_read_before_write();
    test_reset_abort();
    test_back_to_back_lat1();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
